muldiv_hilo_ctrl: RTL and testbench

//  Sequencer for multiply/divide and the HI/LO register pair. Takes MULT/DIV/MTHI/MTLO/MFHI/MFLO

---
 rtl/muldiv_hilo_ctrl_pkg.sv | 21 ++
 rtl/muldiv_hilo_ctrl_div_iter.sv | 60 ++++++
 rtl/muldiv_hilo_ctrl.sv | 154 +++++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_hilo_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer: decode op codes and FSM states.
package muldiv_hilo_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_NOP  = 3'd0,
        MD_MULT = 3'd1,
        MD_DIV  = 3'd2,
        MD_MTHI = 3'd3,
        MD_MTLO = 3'd4,
        MD_MFHI = 3'd5,
        MD_MFLO = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } state_e;

endpackage

// File: rtl/muldiv_hilo_ctrl_div_iter.sv
// Unsigned radix-2 restoring divider: loads on start, iterates WIDTH cycles, then holds ready.
module muldiv_div_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] rem, quo, dvs;
    logic [CW-1:0]    cnt;
    logic             running;
    logic [WIDTH:0]   trial, diff;

    // One extra bit on the trial remainder keeps divisors with the MSB set exact.
    assign trial = {rem, quo[WIDTH-1]};
    assign diff  = trial - {1'b0, dvs};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            cnt     <= '0;
            running <= 1'b0;
            ready   <= 1'b0;
        end else if (start) begin
            rem     <= '0;
            quo     <= dividend;
            dvs     <= divisor;
            cnt     <= '0;
            running <= 1'b1;
            ready   <= 1'b0;
        end else if (running) begin
            if (!diff[WIDTH]) begin
                rem <= diff[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
                rem <= trial[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b0};
            end
            if (cnt == CW'(WIDTH - 1)) begin
                running <= 1'b0;
                ready   <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign quotient  = quo;
    assign remainder = rem;

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO register pair and multiply/divide sequencer; stalls the core while an op is in flight.
module muldiv_hilo_ctrl
    import muldiv_hilo_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [2:0]       md_op,
    input  logic             ifunsigned,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] rd_data,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    state_e state, state_nxt;
    md_op_e op;

    logic                     accept, acc_mul, acc_div, acc_mthi, acc_mtlo;
    logic                     mul_last, mul_wr, fix_wr;
    logic [CNT_W-1:0]         mul_cnt;
    logic                     rs_neg, rt_neg;
    logic signed [2*WIDTH-1:0] mul_a, mul_b;
    logic [2*WIDTH-1:0]       mul_prod;
    logic [2*WIDTH-1:0]       mul_pipe [MUL_LAT];
    logic [WIDTH-1:0]         rs_mag, rt_mag, div_quo, div_rem, rs_hold;
    logic                     div_ready, q_neg, r_neg, dz;

    assign op       = md_op_e'(md_op);
    assign busy     = (state != ST_IDLE);
    assign stall    = op_valid && busy;
    assign accept   = op_valid && !busy && !flush;
    assign acc_mul  = accept && (op == MD_MULT);
    assign acc_div  = accept && (op == MD_DIV);
    assign acc_mthi = accept && (op == MD_MTHI);
    assign acc_mtlo = accept && (op == MD_MTLO);

    assign mul_last = (mul_cnt == CNT_W'(MUL_LAT - 1));
    assign mul_wr   = (state == ST_MUL) && !flush && mul_last;
    assign fix_wr   = (state == ST_FIX) && !flush;

    // Sign-extending to 2*WIDTH makes one signed multiply serve MULT and MULTU.
    assign rs_neg   = !ifunsigned && rs_val[WIDTH-1];
    assign rt_neg   = !ifunsigned && rt_val[WIDTH-1];
    assign mul_a    = {{WIDTH{rs_neg}}, rs_val};
    assign mul_b    = {{WIDTH{rt_neg}}, rt_val};
    assign mul_prod = mul_a * mul_b;

    assign rs_mag   = rs_neg ? -rs_val : rs_val;
    assign rt_mag   = rt_neg ? -rt_val : rt_val;

    muldiv_div_iter #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (acc_div),
        .dividend  (rs_mag),
        .divisor   (rt_mag),
        .quotient  (div_quo),
        .remainder (div_rem),
        .ready     (div_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (acc_mul)      state_nxt = ST_MUL;
                     else if (acc_div) state_nxt = ST_DIV;
            ST_MUL:  if (flush || mul_last) state_nxt = ST_IDLE;
            ST_DIV:  if (flush)          state_nxt = ST_IDLE;
                     else if (div_ready) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        if (op_valid && !busy) begin
            if (op == MD_MFHI)      rd_data = hi;
            else if (op == MD_MFLO) rd_data = lo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            mul_cnt  <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            dz       <= 1'b0;
            rs_hold  <= '0;
            for (int unsigned i = 0; i < MUL_LAT; i++) mul_pipe[i] <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;

            if (acc_mul) begin
                mul_pipe[0] <= mul_prod;
                mul_cnt     <= '0;
            end else if (state == ST_MUL) begin
                mul_cnt <= mul_cnt + CNT_W'(1);
            end
            for (int unsigned i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];

            if (acc_div) begin
                q_neg   <= rs_neg ^ rt_neg;
                r_neg   <= rs_neg;
                dz      <= (rt_val == '0);
                rs_hold <= rs_val;
            end

            if (acc_mthi) hi <= rs_val;
            if (acc_mtlo) lo <= rs_val;

            if (mul_wr) begin
                {hi, lo} <= mul_pipe[MUL_LAT-1];
                done     <= 1'b1;
            end

            if (fix_wr) begin
                done     <= 1'b1;
                div_zero <= dz;
                if (dz) begin
                    lo <= '1;
                    hi <= rs_hold;
                end else begin
                    lo <= q_neg ? -div_quo : div_quo;
                    hi <= r_neg ? -div_rem : div_rem;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl: vector table for MULT/DIV plus hand-written corner sequences.
module tb_muldiv_hilo_ctrl;
    import muldiv_hilo_ctrl_pkg::*;

    localparam int unsigned W = 32;
    localparam int unsigned L = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         op_valid = 1'b0;
    logic [2:0]   md_op = '0;
    logic         ifunsigned = 1'b0;
    logic [W-1:0] rs_val = '0;
    logic [W-1:0] rt_val = '0;
    logic         flush = 1'b0;
    logic         stall, busy, done, div_zero;
    logic [W-1:0] rd_data, hi, lo;

    int errors = 0;
    int checks = 0;

    muldiv_hilo_ctrl #(
        .WIDTH   (W),
        .MUL_LAT (L)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .md_op      (md_op),
        .ifunsigned (ifunsigned),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .flush      (flush),
        .stall      (stall),
        .busy       (busy),
        .rd_data    (rd_data),
        .done       (done),
        .div_zero   (div_zero),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        md_op_e       op;
        logic         uns;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        logic         exp_dz;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        op_valid = 1'b0;
        md_op    = MD_NOP;
        flush    = 1'b0;
    endtask

    task automatic issue(input md_op_e o, input logic uns, input logic [W-1:0] a, input logic [W-1:0] b);
        op_valid   = 1'b1;
        md_op      = o;
        ifunsigned = uns;
        rs_val     = a;
        rt_val     = b;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        int exp_lat;
        issue(v.op, v.uns, v.a, v.b);
        #1;
        chk($sformatf("v%0d_stall_at_issue", idx), 64'(stall), 64'd0);
        step();
        idle_inputs();
        rs_val     = '1;
        rt_val     = 32'h5A5A_5A5A;
        ifunsigned = ~v.uns;
        chk($sformatf("v%0d_busy", idx), 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 100) begin
            step();
            n++;
        end
        exp_lat = (v.op == MD_MULT) ? int'(L) : int'(W + 2);
        chk($sformatf("v%0d_latency", idx), 64'(n), 64'(exp_lat));
        chk($sformatf("v%0d_hi", idx), 64'(hi), 64'(v.exp_hi));
        chk($sformatf("v%0d_lo", idx), 64'(lo), 64'(v.exp_lo));
        chk($sformatf("v%0d_div_zero", idx), 64'(div_zero), 64'(v.exp_dz));
        step();
        chk($sformatf("v%0d_done_pulse", idx), 64'(done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dcount;

        vecs[0]  = '{MD_MULT, 1'b0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{MD_MULT, 1'b1, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
        vecs[2]  = '{MD_MULT, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[3]  = '{MD_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
        vecs[4]  = '{MD_MULT, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[5]  = '{MD_DIV,  1'b0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[6]  = '{MD_DIV,  1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[7]  = '{MD_DIV,  1'b0, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
        vecs[8]  = '{MD_DIV,  1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[9]  = '{MD_DIV,  1'b0, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        vecs[10] = '{MD_DIV,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0};
        vecs[11] = '{MD_DIV,  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         32'd1,         1'b0};

        // Reset state
        #22;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Moves to/from HI/LO
        issue(MD_MFHI, 1'b0, '0, '0);
        #1;
        chk("mfhi_reset", 64'(rd_data), 64'd0);
        chk("mfhi_no_stall", 64'(stall), 64'd0);
        step();
        issue(MD_MFLO, 1'b0, '0, '0);
        #1;
        chk("mflo_reset", 64'(rd_data), 64'd0);
        step();
        issue(MD_MTHI, 1'b0, 32'hDEAD_BEEF, '0);
        #1;
        chk("mthi_rd_data_zero", 64'(rd_data), 64'd0);
        step();
        chk("mthi_hi", 64'(hi), 64'hDEAD_BEEF);
        chk("mthi_lo_kept", 64'(lo), 64'd0);
        issue(MD_MTLO, 1'b0, 32'h1234_5678, '0);
        step();
        chk("mtlo_lo", 64'(lo), 64'h1234_5678);
        issue(MD_MFHI, 1'b0, '0, '0);
        #1;
        chk("mfhi_after_mthi", 64'(rd_data), 64'hDEAD_BEEF);
        step();
        issue(MD_MFLO, 1'b0, '0, '0);
        #1;
        chk("mflo_after_mtlo", 64'(rd_data), 64'h1234_5678);
        step();
        idle_inputs();
        step();

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // MTHI held against a MULT is accepted on the first idle cycle
        issue(MD_MULT, 1'b1, 32'd3, 32'd5);
        step();
        issue(MD_MTHI, 1'b0, 32'h0000_0077, '0);
        n = 0;
        #1;
        while (stall && n < 100) begin
            n++;
            step();
            #1;
        end
        chk("mthi_stall_cycles", 64'(n), 64'(L));
        step();
        idle_inputs();
        chk("mthi_after_mul_hi", 64'(hi), 64'h77);
        chk("mthi_after_mul_lo", 64'(lo), 64'd15);

        // MFLO held behind a DIV
        issue(MD_DIV, 1'b1, 32'd100, 32'd7);
        step();
        idle_inputs();
        step();
        issue(MD_MFLO, 1'b0, '0, '0);
        n = 0;
        #1;
        while (stall && n < 100) begin
            n++;
            step();
            #1;
        end
        chk("mflo_stall_cycles", 64'(n), 64'd33);
        chk("mflo_quotient", 64'(rd_data), 64'd14);
        chk("mflo_stall_released", 64'(stall), 64'd0);
        step();
        idle_inputs();

        // Flush mid-divide
        issue(MD_MTHI, 1'b0, 32'h1111_1111, '0);
        step();
        issue(MD_MTLO, 1'b0, 32'h2222_2222, '0);
        step();
        issue(MD_DIV, 1'b1, 32'd100, 32'd7);
        step();
        idle_inputs();
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        dcount = 0;
        if (done) dcount++;
        repeat (40) begin
            step();
            if (done) dcount++;
        end
        chk("flush_no_done", 64'(dcount), 64'd0);
        chk("flush_hi_kept", 64'(hi), 64'h1111_1111);
        chk("flush_lo_kept", 64'(lo), 64'h2222_2222);

        // op_valid coincident with flush is dropped
        issue(MD_MTHI, 1'b0, 32'h3333_3333, '0);
        flush = 1'b1;
        step();
        issue(MD_MULT, 1'b0, 32'd2, 32'd2);
        step();
        idle_inputs();
        chk("flush_drop_mthi", 64'(hi), 64'h1111_1111);
        chk("flush_drop_mult", 64'(busy), 64'd0);

        // Reset in the middle of a MULT
        issue(MD_MULT, 1'b0, 32'hFFFF_FFFD, 32'd7);
        step();
        idle_inputs();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_hi", 64'(hi), 64'd0);
        chk("rst_mid_lo", 64'(lo), 64'd0);
        op_valid = 1'b1;
        md_op    = MD_MFHI;
        #1;
        chk("rst_mid_stall", 64'(stall), 64'd0);
        op_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        chk("rst_mid_no_done", 64'(done), 64'd0);
        chk("rst_mid_hi_after", 64'(hi), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
